// File: rtl/ps2_scancode_queue_if.sv
// ----------------------------------------------------------------------------
// ps2_scancode_queue_if
//   Byte handshake between the PS/2 receiver (master) and the scan-code
//   decoder/queue (slave).
//
//   sc_valid_i : one-cycle strobe, a new received byte is available
//   sc_data_i  : received byte, valid with sc_valid_i
//   sc_perr_i  : parity error flag for that byte, valid with sc_valid_i
//   sc_ack_o   : one-cycle pulse back to the receiver, byte consumed
//
//   The _i/_o suffixes are named from the queue's point of view.
// ----------------------------------------------------------------------------
interface ps2_scancode_queue_if;
    logic       sc_valid_i;
    logic [7:0] sc_data_i;
    logic       sc_perr_i;
    logic       sc_ack_o;

    modport master (
        output sc_valid_i,
        output sc_data_i,
        output sc_perr_i,
        input  sc_ack_o
    );

    modport slave (
        input  sc_valid_i,
        input  sc_data_i,
        input  sc_perr_i,
        output sc_ack_o
    );
endinterface

// File: rtl/ps2_scancode_queue.sv
// ----------------------------------------------------------------------------
// ps2_scancode_queue
//   Downstream stage of the PS/2 keyboard interface. Each received byte is
//   acknowledged one cycle later. Set-2 prefix sequences (E0 extended,
//   F0 break, E1 pause) are decoded. Modifier and caps-lock state are
//   tracked. Complete key events are queued in a first-word-fall-through
//   FIFO for the CPU.
//
//   Event word layout:
//     [7:0] code, [8] ext, [9] break, [10] pause, [11] sys,
//     [12] shift, [13] ctrl, [14] alt, [15] caps-lock state
//
//   Ports:
//     clk_i, rst_ni  clock, asynchronous active-low reset
//     sc             byte handshake from the receiver (slave modport)
//     rd_i           pop the head event
//     event_o        head event, 0 when the FIFO is empty
//     empty_o        FIFO empty flag
//     full_o         FIFO full flag
//     count_o        FIFO occupancy
//     irq_en_i       interrupt enable
//     irq_o          registered irq_en_i & ~empty_o
//     clr_i          synchronous clear of the FIFO, the sticky flags and the
//                    decoder state
//     ovf_o          sticky flag: overrun byte, or event dropped on a full FIFO
//     perr_o         sticky flag: byte discarded for a parity error
// ----------------------------------------------------------------------------
module ps2_scancode_queue #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    ps2_scancode_queue_if.slave  sc,
    input  logic                 rd_i,
    output logic [15:0]          event_o,
    output logic                 empty_o,
    output logic                 full_o,
    output logic [AW:0]          count_o,
    input  logic                 irq_en_i,
    output logic                 irq_o,
    input  logic                 clr_i,
    output logic                 ovf_o,
    output logic                 perr_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXTBRK,
        S_PAUSE
    } state_e;

    // Decoder state
    state_e      state_q, state_d;
    logic [2:0]  skip_q, skip_d;

    // Modifier state; each side of a modifier pair is tracked separately
    logic        lShift_q, lShift_d;
    logic        rShift_q, rShift_d;
    logic        lCtrl_q, lCtrl_d;
    logic        rCtrl_q, rCtrl_d;
    logic        lAlt_q, lAlt_d;
    logic        rAlt_q, rAlt_d;
    logic        caps_q, caps_d;
    logic        capsHeld_q, capsHeld_d;

    // Handshake, interrupt and sticky flags
    logic        ack_q;
    logic        irq_q;
    logic        ovf_q, ovf_d;
    logic        perr_q, perr_d;

    // FIFO
    logic [15:0] mem [DEPTH];
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW:0]   count_q, count_d;

    // Decode results for the current byte
    logic        pushReq;
    logic [7:0]  pushCode;
    logic        extBit;
    logic        brkBit;
    logic        pauseBit;
    logic        sysBit;
    logic        overrunByte;
    logic        parityDrop;
    logic        doPop;
    logic        doWrite;
    logic        dropPush;
    logic [15:0] eventWord;

    assign empty_o     = (count_q == '0);
    assign full_o      = (count_q == (AW+1)'(DEPTH));
    assign count_o     = count_q;
    assign event_o     = empty_o ? 16'h0000 : mem[rdPtr_q];
    assign irq_o       = irq_q;
    assign ovf_o       = ovf_q;
    assign perr_o      = perr_q;
    assign sc.sc_ack_o = ack_q;

    // Byte decoder. A byte arriving while clr_i is high is only acknowledged.
    // The modifier update runs on the decoded event so the event word carries
    // the modifier state that includes this key.
    always_comb begin
        state_d     = state_q;
        skip_d      = skip_q;
        pushReq     = 1'b0;
        pushCode    = sc.sc_data_i;
        extBit      = 1'b0;
        brkBit      = 1'b0;
        pauseBit    = 1'b0;
        sysBit      = 1'b0;
        overrunByte = 1'b0;
        parityDrop  = 1'b0;

        if (sc.sc_valid_i && !clr_i) begin
            if (sc.sc_perr_i) begin
                parityDrop = 1'b1;
                state_d    = S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        case (sc.sc_data_i)
                            8'hE0: state_d = S_EXT;
                            8'hF0: state_d = S_BRK;
                            8'hE1: begin
                                state_d = S_PAUSE;
                                skip_d  = 3'd7;
                            end
                            8'hAA, 8'hFA, 8'hEE, 8'hFE: begin
                                pushReq = 1'b1;
                                sysBit  = 1'b1;
                            end
                            8'h00, 8'hFF: overrunByte = 1'b1;
                            default: pushReq = 1'b1;
                        endcase
                    end
                    S_EXT: begin
                        if (sc.sc_data_i == 8'hF0) begin
                            state_d = S_EXTBRK;
                        end else begin
                            pushReq = 1'b1;
                            extBit  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                    S_BRK: begin
                        pushReq = 1'b1;
                        brkBit  = 1'b1;
                        state_d = S_IDLE;
                    end
                    S_EXTBRK: begin
                        pushReq = 1'b1;
                        extBit  = 1'b1;
                        brkBit  = 1'b1;
                        state_d = S_IDLE;
                    end
                    S_PAUSE: begin
                        // The seven bytes after E1 are swallowed; the last
                        // one produces the single pause event.
                        skip_d = skip_q - 3'd1;
                        if (skip_q == 3'd1) begin
                            pushReq  = 1'b1;
                            pushCode = 8'h77;
                            pauseBit = 1'b1;
                            state_d  = S_IDLE;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end

        if (clr_i) begin
            state_d = S_IDLE;
            skip_d  = 3'd0;
        end
    end

    // Modifier tracking. E0 12 / E0 59 are fake shifts and fall through the
    // extended case without effect. Caps toggles only on the first make
    // after a break, so typematic repeats leave it alone.
    always_comb begin
        lShift_d   = lShift_q;
        rShift_d   = rShift_q;
        lCtrl_d    = lCtrl_q;
        rCtrl_d    = rCtrl_q;
        lAlt_d     = lAlt_q;
        rAlt_d     = rAlt_q;
        caps_d     = caps_q;
        capsHeld_d = capsHeld_q;

        if (pushReq && !sysBit && !pauseBit) begin
            if (!extBit) begin
                case (pushCode)
                    8'h12: lShift_d = ~brkBit;
                    8'h59: rShift_d = ~brkBit;
                    8'h14: lCtrl_d  = ~brkBit;
                    8'h11: lAlt_d   = ~brkBit;
                    8'h58: begin
                        if (brkBit) begin
                            capsHeld_d = 1'b0;
                        end else begin
                            if (!capsHeld_q) begin
                                caps_d = ~caps_q;
                            end
                            capsHeld_d = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end else begin
                case (pushCode)
                    8'h14: rCtrl_d = ~brkBit;
                    8'h11: rAlt_d  = ~brkBit;
                    default: ;
                endcase
            end
        end

        eventWord = {caps_d, lAlt_d | rAlt_d, lCtrl_d | rCtrl_d,
                     lShift_d | rShift_d, sysBit, pauseBit, brkBit, extBit,
                     pushCode};
    end

    // FIFO bookkeeping. A push into a full FIFO only succeeds when a pop
    // frees the slot in the same cycle; a pop on an empty FIFO is ignored,
    // so push+pop while empty degenerates to a plain push.
    always_comb begin
        doPop    = rd_i && !empty_o;
        doWrite  = pushReq && (!full_o || doPop);
        dropPush = pushReq && full_o && !doPop;

        rdPtr_d = doPop   ? rdPtr_q + AW'(1) : rdPtr_q;
        wrPtr_d = doWrite ? wrPtr_q + AW'(1) : wrPtr_q;

        case ({doWrite, doPop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase

        ovf_d  = ovf_q | overrunByte | dropPush;
        perr_d = perr_q | parityDrop;

        if (clr_i) begin
            rdPtr_d = '0;
            wrPtr_d = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            perr_d  = 1'b0;
        end
    end

    // State registers. The ack tracks every strobe regardless of what the
    // decoder did with the byte.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            skip_q     <= 3'd0;
            lShift_q   <= 1'b0;
            rShift_q   <= 1'b0;
            lCtrl_q    <= 1'b0;
            rCtrl_q    <= 1'b0;
            lAlt_q     <= 1'b0;
            rAlt_q     <= 1'b0;
            caps_q     <= 1'b0;
            capsHeld_q <= 1'b0;
            ack_q      <= 1'b0;
            irq_q      <= 1'b0;
            ovf_q      <= 1'b0;
            perr_q     <= 1'b0;
            rdPtr_q    <= '0;
            wrPtr_q    <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            skip_q     <= skip_d;
            lShift_q   <= lShift_d;
            rShift_q   <= rShift_d;
            lCtrl_q    <= lCtrl_d;
            rCtrl_q    <= rCtrl_d;
            lAlt_q     <= lAlt_d;
            rAlt_q     <= rAlt_d;
            caps_q     <= caps_d;
            capsHeld_q <= capsHeld_d;
            ack_q      <= sc.sc_valid_i;
            irq_q      <= irq_en_i & ~empty_o;
            ovf_q      <= ovf_d;
            perr_q     <= perr_d;
            rdPtr_q    <= rdPtr_d;
            wrPtr_q    <= wrPtr_d;
            count_q    <= count_d;
        end
    end

    // Event storage; contents need no reset because event_o is masked
    // while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (doWrite) begin
            mem[wrPtr_q] <= eventWord;
        end
    end

endmodule

// File: doc/ps2_scancode_queue.md
Name: ps2_scancode_queue

Overview:
- Downstream stage of the PS2 keyboard interface. Consumes each raw received byte (scan code plus parity status) and decodes PS/2 Set-2 prefix sequences (E0, F0, E1 pause).
- Tracks modifier state and queues 16-bit key events in a first-word-fall-through FIFO for the CPU.
- Returns a one-cycle acknowledge per byte so the upstream receiver can clear its register and release the keyboard clock inhibit.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..256.
- AW, $clog2(DEPTH), FIFO pointer width.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- sc_valid_i  in  1  one-cycle strobe: new received byte available.
- sc_data_i  in  8  received byte, valid with sc_valid_i.
- sc_perr_i  in  1  parity error on this byte, valid with sc_valid_i.
- sc_ack_o  out  1  one-cycle pulse: byte consumed, upstream may clear.
- rd_i  in  1  pop head event.
- event_o  out  16  head event; 0 when empty.
- empty_o  out  1  FIFO empty.
- full_o  out  1  FIFO full.
- count_o  out  AW+1  occupancy.
- irq_en_i  in  1  interrupt enable.
- irq_o  out  1  irq_en_i & ~empty_o, registered.
- clr_i  in  1  clear sticky flags, FIFO contents and decoder state.
- ovf_o  out  1  sticky: event dropped because FIFO full.
- perr_o  out  1  sticky: byte discarded for parity error.

Behaviour:
- Reset (rst_ni low, async): decoder IDLE, FIFO empty, modifiers and caps 0. Outputs: sc_ack_o=0, ovf_o=0, perr_o=0, irq_o=0, empty_o=1, full_o=0, count_o=0, event_o=0.
- Event format:
  - [7:0] code; [8] ext (E0 seen); [9] break (F0 seen); [10] pause; [11] sys.
  - [12] shift; [13] ctrl; [14] alt; [15] caps-lock state.
  - Modifier bits [15:12] are sampled after the current byte's modifier update.
- Byte timing: sc_valid_i sampled at edge N. sc_ack_o is high for the cycle after edge N, exactly once per strobe, including for prefix, discarded and parity-error bytes. Any resulting push is visible (empty_o, count_o, event_o) after edge N.
- Parity error: byte discarded, perr_o set, decoder returns to IDLE, no push.
- Decoder FSM:
  - IDLE:
    - E0 -> EXT.
    - F0 -> BRK.
    - E1 -> PAUSE; skip counter = 7.
    - AA/FA/EE/FE -> push with sys=1, code=byte.
    - 00/FF (overrun) -> discard, set ovf_o.
    - Any other byte -> push make event.
  - EXT: F0 -> EXTBRK; any other byte -> push ext=1, back to IDLE.
  - BRK: push break=1, back to IDLE.
  - EXTBRK: push ext=1, break=1, back to IDLE.
  - PAUSE: each byte decrements the counter. At 0, push code=0x77, pause=1 and go to IDLE. No push for the intermediate bytes.
- Modifiers, applied in the same cycle as the push:
  - shift = L(12) | R(59). Each side is set on make and cleared on break.
  - ctrl = L(14) | R(E0 14).
  - alt = L(11) | R(E0 11).
  - E0 12 and E0 59 (fake shifts) are queued but do not change shift.
  - Caps (58): toggles on a make while caps_held=0, then sets caps_held. Break clears caps_held, so typematic repeats do not re-toggle.
- FIFO:
  - event_o = mem[rd_ptr] combinationally.
  - rd_i while empty is ignored.
  - Push while full: event dropped, ovf_o set. Exception: rd_i in the same cycle, where both occur and count is unchanged.
  - Push and pop while empty: push only.
  - Pointers wrap modulo DEPTH.
- clr_i: synchronous, one cycle. Empties the FIFO, clears ovf_o, perr_o and the decoder state. Modifier and caps state are kept. A byte arriving in the same cycle is acked and discarded.
- Async reset mid-sequence (e.g. after E0): decoder IDLE, no event.

Test Plan:
- Bytes 1C, F0, 1C -> sc_ack_o pulses 3 times; events 0x001C then 0x021C; count_o=2; irq_o=1 with irq_en_i=1.
- 12, 1C, F0 12, 1C -> events 0x1012, 0x101C, 0x0212 (break clears shift, so bit 12=0), 0x001C.
- E0 14 then E0 F0 14 -> 0x2114, 0x0314. Then 58 sent 3 times (typematic), F0 58, 58 -> caps bit: 1, 1, 1, 1 on break (0x8258), then 0 on the next make.
- E1 14 77 E1 F0 14 F0 77 -> exactly one event 0x0477; 8 acks.
- DEPTH=16: push 17 makes -> full_o=1, ovf_o=1, 17th dropped. At full, push and pop in the same cycle -> count stays 16. clr_i -> count 0, ovf_o=0.
- Byte with sc_perr_i=1 after E0 -> perr_o=1, no event; next byte 1C -> 0x001C (ext=0). rst_ni low mid-queue -> all outputs at reset values immediately.
